// File: rtl/code_decoder_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : code_decoder_stream_if
// Brief    : Code-in / one-hot-out stream bundle for code_decoder_stream.
//            dec_count exists only when DEC_COUNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface code_decoder_stream_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             Y0;
    logic             Y1;
    logic             Y2;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       D;
    logic [LVL_W-1:0] level;
`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] dec_count;
`endif

    // Driver side: produces codes, consumes decoded words.
    modport master (
        output in_valid, Y0, Y1, Y2, out_ready,
        input  in_ready, out_valid, D, level
`ifdef DEC_COUNT_EN
        , input dec_count
`endif
    );

    // Decoder side.
    modport slave (
        input  in_valid, Y0, Y1, Y2, out_ready,
        output in_ready, out_valid, D, level
`ifdef DEC_COUNT_EN
        , output dec_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/code_decoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : code_decoder_stream
// Brief    : Streaming 3-to-8 decoder: code FIFO feeding a registered one-hot
//            output stage. Optional macro DEC_COUNT_EN adds dec_count.
// Revision : 1.0  initial release
// ============================================================================
module code_decoder_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    code_decoder_stream_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_param_check
        $error("code_decoder_stream: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic [2:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             r_out_valid;
    logic [7:0]       r_d;

    logic w_in_ready;
    logic w_push;
    logic w_load_en;
    logic w_pop;

    // in_ready is from registered level only, so a same-cycle pop never frees a full FIFO.
    assign w_in_ready = (r_level != C_FULL);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_load_en  = !r_out_valid || bus.out_ready;
    assign w_pop      = w_load_en && (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.Y0, bus.Y1, bus.Y2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_d         <= 8'h00;
        end else if (w_load_en) begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_d         <= 8'd1 << r_mem[r_rptr];
            end else begin
                r_out_valid <= 1'b0;
                r_d         <= 8'h00;
            end
        end
    end

`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] r_dec_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_count <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_dec_count <= r_dec_count + 1'b1;
        end
    end

    assign bus.dec_count = r_dec_count;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.D         = r_d;
    assign bus.level     = r_level;
endmodule
`default_nettype wire

// File: tb/tb_code_decoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_decoder_stream
// Brief    : Directed self-checking bench for code_decoder_stream (DEPTH=4,
//            CNT_W=4); dec_count checks only when DEC_COUNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_code_decoder_stream;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    code_decoder_stream_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    code_decoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] code);
        bus.in_valid = v;
        {bus.Y0, bus.Y1, bus.Y2} = code;
    endtask

    initial begin
        logic [2:0] codes [5];
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0);
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_D",         32'(bus.D),         32'h00);
        chk("rst_level",     32'(bus.level),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // single code 101
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b101);
        step();
        drive(1'b0, 3'd0);
        chk("single_lat1_valid", 32'(bus.out_valid), 32'd0);
        chk("single_lat1_level", 32'(bus.level),     32'd1);
        step();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_D",     32'(bus.D),         32'h20);
        step();
        chk("single_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("single_idle_D",     32'(bus.D),         32'h00);

        // back-to-back codes 0..7
        drive(1'b1, 3'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive(1'b1, 3'(i + 1));
            else       drive(1'b0, 3'd0);
            step();
            chk("stream_valid",    32'(bus.out_valid), 32'd1);
            chk("stream_D",        32'(bus.D),         32'd1 << i);
            chk("stream_in_ready", 32'(bus.in_ready),  32'd1);
        end
        step();
        chk("stream_end_valid", 32'(bus.out_valid), 32'd0);

        // backpressure fill: 5 codes, DEPTH 4
        codes[0] = 3'd3; codes[1] = 3'd6; codes[2] = 3'd1; codes[3] = 3'd7; codes[4] = 3'd2;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, codes[i]);
            step();
        end
        drive(1'b0, 3'd0);
        chk("full_level",    32'(bus.level),     32'd4);
        chk("full_in_ready", 32'(bus.in_ready),  32'd0);
        chk("full_valid",    32'(bus.out_valid), 32'd1);
        chk("full_D",        32'(bus.D),         32'h08);
        step();
        chk("hold_D", 32'(bus.D), 32'h08);
        bus.out_ready = 1'b1;
        step();
        chk("drain_D0",       32'(bus.D),        32'h40);
        chk("drain_level0",   32'(bus.level),    32'd3);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("drain_D1", 32'(bus.D), 32'h02);
        step();
        chk("drain_D2", 32'(bus.D), 32'h80);
        step();
        chk("drain_D3",     32'(bus.D),     32'h04);
        chk("drain_level3", 32'(bus.level), 32'd0);
        step();
        chk("drain_end_valid", 32'(bus.out_valid), 32'd0);

        // full FIFO, push attempt + pop in the same cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i));
            step();
        end
        drive(1'b1, 3'd5);
        bus.out_ready = 1'b1;
        chk("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        drive(1'b0, 3'd0);
        chk("fullpop_level", 32'(bus.level), 32'd3);
        chk("fullpop_D1",    32'(bus.D),     32'h02);
        step();
        chk("fullpop_D2", 32'(bus.D), 32'h04);
        step();
        chk("fullpop_D3", 32'(bus.D), 32'h08);
        step();
        chk("fullpop_D4", 32'(bus.D), 32'h10);
        step();
        chk("fullpop_no_dup", 32'(bus.out_valid), 32'd0);

        // asynchronous reset with level 3
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(7 - i));
            step();
        end
        drive(1'b0, 3'd0);
        chk("pre_arst_level", 32'(bus.level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_D",     32'(bus.D),         32'h00);
        chk("arst_level", 32'(bus.level),     32'd0);
`ifdef DEC_COUNT_EN
        chk("arst_count", 32'(bus.dec_count), 32'd0);
`endif
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd6);
        step();
        drive(1'b0, 3'd0);
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_D",     32'(bus.D),         32'h40);
        step();

`ifdef DEC_COUNT_EN
        // 1 handshake so far; 16 more wraps a 4-bit counter back to 1
        chk("count_after_one", 32'(bus.dec_count), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'(i));
            step();
        end
        drive(1'b0, 3'd0);
        step();
        step();
        chk("count_wrap", 32'(bus.dec_count), 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(i));
            step();
        end
        drive(1'b0, 3'd0);
        step();
        chk("count_stalled", 32'(bus.dec_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
